// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel synchroniser, debouncer and edge detector
// Emits debounced levels, one-cycle event pulses and a lowest-index event summary.
module button_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0,
    parameter int IDLE_LEVEL      = 0
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [CHANNELS-1:0]                         async_in,
    output logic [CHANNELS-1:0]                         level,
    output logic [CHANNELS-1:0]                         pulse,
    output logic                                        event_valid,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] event_idx
);

    localparam int   IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int   CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic IDLE_BIT = (IDLE_LEVEL != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge_mode
            $error("button_conditioner: EDGE_MODE must be 0, 1 or 2");
        end
        if (CHANNELS < 1) begin : g_bad_channels
            $error("button_conditioner: CHANNELS must be at least 1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("button_conditioner: SYNC_STAGES must be at least 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    // Plain flop chain: no logic between stages so every stage can resolve metastability.
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= {CHANNELS{IDLE_BIT}};
            end
        end else begin
            sync_q[0] <= async_in;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            logic [CNT_W-1:0] cnt_q;
            logic             level_q;
            logic             pulse_q;
            logic             edge_hit;

            // s[i] is the level about to be accepted, so it decides rise versus fall.
            assign edge_hit = (EDGE_MODE == 2) ? 1'b1 :
                              (EDGE_MODE == 1) ? ~s[i] : s[i];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q   <= '0;
                    level_q <= IDLE_BIT;
                    pulse_q <= 1'b0;
                end else if (s[i] == level_q) begin
                    cnt_q   <= '0;
                    pulse_q <= 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    level_q <= s[i];
                    cnt_q   <= '0;
                    pulse_q <= edge_hit;
                end else begin
                    cnt_q   <= cnt_q + 1'b1;
                    pulse_q <= 1'b0;
                end
            end

            assign level[i] = level_q;
            assign pulse[i] = pulse_q;
        end
    endgenerate

    // Scan from the top down so the lowest-numbered active channel wins.
    always_comb begin
        event_idx   = '0;
        event_valid = |pulse;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pulse[i]) begin
                event_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed bench for button_conditioner
// Five configurations share one stimulus; a window-based reference model predicts every output.
module tb_button_conditioner;

    localparam int NDUT = 5;
    localparam int HMAX = 8192;
    localparam int SYN [NDUT] = '{2, 2, 2, 2, 3};
    localparam int DEB [NDUT] = '{4, 4, 4, 1, 5};
    localparam int EM  [NDUT] = '{0, 1, 2, 1, 2};
    localparam int IDL [NDUT] = '{0, 0, 0, 1, 1};
    localparam int CH  [NDUT] = '{4, 4, 4, 4, 3};

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] async_in = 4'b0000;
    logic [3:0] in_inv;
    logic [NDUT-1:0][3:0] lvl;
    logic [NDUT-1:0][3:0] pls;
    logic [NDUT-1:0]      ev;
    logic [NDUT-1:0][1:0] idx;
    logic [2:0] lvl4;
    logic [2:0] pls4;

    int vectors = 0;
    int miscompares = 0;

    // Model state: edge index since reset release, input history, per-channel results.
    int   n;
    logic [3:0] in_hist [HMAX];
    int   last_acc [NDUT][4];
    logic mlevel   [NDUT][4];
    logic mpulse   [NDUT][4];

    always #5 clk = ~clk;

    // Idle-high configurations see the inverted input so one stimulus works for all.
    assign in_inv = ~async_in;

    button_conditioner #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .IDLE_LEVEL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .level(lvl[0]), .pulse(pls[0]),
        .event_valid(ev[0]), .event_idx(idx[0]));
    button_conditioner #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .IDLE_LEVEL(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .level(lvl[1]), .pulse(pls[1]),
        .event_valid(ev[1]), .event_idx(idx[1]));
    button_conditioner #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .IDLE_LEVEL(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .level(lvl[2]), .pulse(pls[2]),
        .event_valid(ev[2]), .event_idx(idx[2]));
    button_conditioner #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_MODE(1), .IDLE_LEVEL(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .async_in(in_inv), .level(lvl[3]), .pulse(pls[3]),
        .event_valid(ev[3]), .event_idx(idx[3]));
    button_conditioner #(.CHANNELS(3), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(5), .EDGE_MODE(2), .IDLE_LEVEL(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .async_in(in_inv[2:0]), .level(lvl4), .pulse(pls4),
        .event_valid(ev[4]), .event_idx(idx[4]));

    assign lvl[4] = {1'b0, lvl4};
    assign pls[4] = {1'b0, pls4};

    task automatic model_reset();
        n = 0;
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < 4; c++) begin
                last_acc[d][c] = -1;
                mlevel[d][c]   = (IDL[d] != 0);
                mpulse[d][c]   = 1'b0;
            end
        end
    endtask

    // Synchronised value the debouncer sees at edge m: the input captured SYNC edges earlier.
    function automatic logic s_at(int d, int c, int m);
        logic idle;
        idle = (IDL[d] != 0);
        if (m - SYN[d] < 0) return idle;
        return in_hist[m - SYN[d]][c] ^ idle;
    endfunction

    // A value is accepted once it has differed from the level on DEB consecutive edges,
    // all of them later than the previous acceptance.
    task automatic model_step();
        logic acc;
        if (n >= HMAX) return;
        in_hist[n] = async_in;
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < CH[d]; c++) begin
                acc = (n - DEB[d] + 1 > last_acc[d][c]);
                for (int j = 0; j < DEB[d]; j++) begin
                    if (acc && s_at(d, c, n - j) == mlevel[d][c]) acc = 1'b0;
                end
                if (acc) begin
                    mlevel[d][c]   = ~mlevel[d][c];
                    last_acc[d][c] = n;
                    mpulse[d][c]   = (EM[d] == 2) || (EM[d] == 0 && mlevel[d][c]) ||
                                     (EM[d] == 1 && !mlevel[d][c]);
                end else begin
                    mpulse[d][c] = 1'b0;
                end
            end
        end
        n++;
    endtask

    task automatic check(string nm, int d, logic [3:0] act, logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %b expected %b at %0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [3:0] el, ep, ei;
        for (int d = 0; d < NDUT; d++) begin
            el = '0;
            ep = '0;
            ei = '0;
            for (int c = 0; c < CH[d]; c++) begin
                el[c] = mlevel[d][c];
                ep[c] = mpulse[d][c];
            end
            for (int c = 3; c >= 0; c--) begin
                if (ep[c]) ei = 4'(c);
            end
            check("model_level", d, lvl[d], el);
            check("model_pulse", d, pls[d], ep);
            check("model_event_valid", d, {3'b000, ev[d]}, {3'b000, |ep});
            check("model_event_idx", d, {2'b00, idx[d]}, ei);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_model();
    endtask

    // Assert reset between edges, check the immediate clear, hold two edges, release.
    task automatic do_reset();
        #7;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_model();
        check("async_rst_level", 0, lvl[0], 4'b0000);
        check("async_rst_pulse", 0, pls[0], 4'b0000);
        check("async_rst_lvl_idle1", 3, lvl[3], 4'b1111);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int rate;
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        for (int d = 0; d < NDUT; d++) begin
            check("reset_level", d, lvl[d], (IDL[d] != 0) ? 4'((1 << CH[d]) - 1) : 4'b0000);
            check("reset_pulse", d, pls[d], 4'b0000);
            check("reset_event_valid", d, {3'b000, ev[d]}, 4'b0000);
            check("reset_event_idx", d, {2'b00, idx[d]}, 4'b0000);
        end
        rst_n = 1'b1;

        // Ch2 rises before edge 10 and is held.
        repeat (9) tick();
        async_in[2] = 1'b1;
        for (int e = 10; e <= 16; e++) begin
            tick();
            if (e == 12) begin
                check("d1_pulse_e12", 3, pls[3], 4'b0100);
                check("d1_level_e12", 3, lvl[3], 4'b1011);
            end
            if (e == 14) check("rise_level_e14", 0, lvl[0], 4'b0000);
            if (e == 15) begin
                check("rise_level_e15", 0, lvl[0], 4'b0100);
                check("rise_pulse_e15", 0, pls[0], 4'b0100);
                check("rise_valid_e15", 0, {3'b000, ev[0]}, 4'b0001);
                check("rise_idx_e15", 0, {2'b00, idx[0]}, 4'b0010);
                check("fall_mode_pulse_e15", 1, pls[1], 4'b0000);
                check("both_mode_pulse_e15", 2, pls[2], 4'b0100);
            end
            if (e == 16) begin
                check("rise_pulse_e16", 0, pls[0], 4'b0000);
                check("rise_level_e16", 0, lvl[0], 4'b0100);
            end
        end
        repeat (10) tick();
        async_in[2] = 1'b0;
        repeat (6) tick();
        check("release_pulse", 0, pls[0], 4'b0000);
        check("release_level", 0, lvl[0], 4'b0000);
        check("release_fall_pulse", 1, pls[1], 4'b0100);
        check("release_both_pulse", 2, pls[2], 4'b0100);
        repeat (6) tick();

        // Bounce on ch0 with 3-cycle segments, then a clean press.
        for (int v = 0; v < 4; v++) begin
            async_in[0] = (v % 2 == 0);
            repeat (3) tick();
        end
        check("bounce_level", 0, lvl[0], 4'b0000);
        async_in[0] = 1'b1;
        repeat (5) tick();
        check("press_pulse_early", 0, pls[0], 4'b0000);
        tick();
        check("press_pulse", 0, pls[0], 4'b0001);
        check("press_level", 0, lvl[0], 4'b0001);
        async_in[0] = 1'b0;
        repeat (10) tick();

        // Simultaneous rise on ch1 and ch3.
        async_in = 4'b1010;
        repeat (3) tick();
        check("simul_d1_pulse", 3, pls[3], 4'b1010);
        check("simul_pulse_early", 0, pls[0], 4'b0000);
        repeat (3) tick();
        check("simul_pulse", 0, pls[0], 4'b1010);
        check("simul_valid", 0, {3'b000, ev[0]}, 4'b0001);
        check("simul_idx", 0, {2'b00, idx[0]}, 4'b0001);
        tick();
        check("simul_pulse_gone", 0, pls[0], 4'b0000);
        check("simul_level", 0, lvl[0], 4'b1010);
        async_in = 4'b0000;
        repeat (10) tick();

        // Reset part-way through a count.
        async_in[0] = 1'b1;
        repeat (4) tick();
        do_reset();
        repeat (5) tick();
        check("post_rst_pulse_early", 0, pls[0], 4'b0000);
        tick();
        check("post_rst_pulse", 0, pls[0], 4'b0001);
        check("post_rst_level", 0, lvl[0], 4'b0001);

        // Random phase with varying bounce density and occasional resets.
        rate = 2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) rate = $urandom_range(1, 4);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, (1 << rate) - 1) == 0) async_in[c] = ~async_in[c];
            end
            if ($urandom_range(0, 599) == 0) do_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
